cpu_multicycle_control: RTL

//  Multicycle RV32I main controller. Sequences the shared datapath (ALU, immediate

---
 rtl/cpu_multicycle_control_pkg.sv | 97 +++++++++
 rtl/cpu_multicycle_control_if.sv | 30 +++
 rtl/cpu_multicycle_control_alu_decoder.sv | 39 +++
 rtl/cpu_multicycle_control.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_multicycle_control_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encoding, opcodes,
// datapath select codes, immediate-extender selects and ALU operation codes.
package cpu_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JAL_LINK  = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Same codes as the immediate extender; I is zero so idle outputs stay all-zero.
  localparam logic [2:0] IMM_SRC_I = 3'd0;
  localparam logic [2:0] IMM_SRC_S = 3'd1;
  localparam logic [2:0] IMM_SRC_B = 3'd2;
  localparam logic [2:0] IMM_SRC_U = 3'd3;
  localparam logic [2:0] IMM_SRC_J = 3'd4;

  localparam logic [1:0] ALU_SRC_A_PC     = 2'd0;
  localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] ALU_SRC_A_RS1    = 2'd2;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RESULT_SRC_ALUOUT = 2'd0;
  localparam logic [1:0] RESULT_SRC_MEM    = 2'd1;
  localparam logic [1:0] RESULT_SRC_ALU    = 2'd2;

  // SLT and SHIFT are families: the ALU picks signedness/direction from funct3/instr[30].
  localparam logic [2:0] ALU_CTRL_ADD    = 3'd0;
  localparam logic [2:0] ALU_CTRL_SUB    = 3'd1;
  localparam logic [2:0] ALU_CTRL_AND    = 3'd2;
  localparam logic [2:0] ALU_CTRL_OR     = 3'd3;
  localparam logic [2:0] ALU_CTRL_XOR    = 3'd4;
  localparam logic [2:0] ALU_CTRL_SLT    = 3'd5;
  localparam logic [2:0] ALU_CTRL_SHIFT  = 3'd6;
  localparam logic [2:0] ALU_CTRL_PASS_B = 3'd7;

  typedef enum logic [2:0] {
    ALU_OP_ADD    = 3'd0,
    ALU_OP_SUB    = 3'd1,
    ALU_OP_RTYPE  = 3'd2,
    ALU_OP_ITYPE  = 3'd3,
    ALU_OP_PASS_B = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic [1:0] result_src;
    logic       trap;
  } ctrl_t;

  // DECODE precomputes the branch/jump target, so only B and J differ from I there.
  function automatic logic [2:0] decode_imm_src(input logic [6:0] opcode);
    logic [2:0] sel;
    case (opcode)
      OP_BRANCH: sel = IMM_SRC_B;
      OP_JAL:    sel = IMM_SRC_J;
      default:   sel = IMM_SRC_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cpu_multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memory (slave).
interface cpu_multicycle_control_if;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [2:0]  imm_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic [1:0]  result_src;
  logic        trap;

  modport master (
    input  instr, branch_taken, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
    output imm_src, alu_src_a, alu_src_b, alu_control, result_src, trap
  );

  modport slave (
    output instr, branch_taken, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
    input  imm_src, alu_src_a, alu_src_b, alu_control, result_src, trap
  );
endinterface

// File: rtl/cpu_multicycle_control_alu_decoder.sv
// ALU decoder: maps the controller's operation class plus funct3/funct7[5] to alu_control.
module cpu_alu_decoder
  import cpu_multicycle_control_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  logic sub_s;

  // funct7[5] selects SUB only for register-register ops; addi ignores it.
  assign sub_s = (alu_op == ALU_OP_RTYPE) ? funct7_5 : 1'b0;

  // Operation-class and funct decode.
  always_comb begin
    alu_control = ALU_CTRL_ADD;
    case (alu_op)
      ALU_OP_ADD:    alu_control = ALU_CTRL_ADD;
      ALU_OP_SUB:    alu_control = ALU_CTRL_SUB;
      ALU_OP_PASS_B: alu_control = ALU_CTRL_PASS_B;
      ALU_OP_RTYPE,
      ALU_OP_ITYPE: begin
        case (funct3)
          3'b000:         alu_control = sub_s ? ALU_CTRL_SUB : ALU_CTRL_ADD;
          3'b001, 3'b101: alu_control = ALU_CTRL_SHIFT;
          3'b010, 3'b011: alu_control = ALU_CTRL_SLT;
          3'b100:         alu_control = ALU_CTRL_XOR;
          3'b110:         alu_control = ALU_CTRL_OR;
          3'b111:         alu_control = ALU_CTRL_AND;
          default:        alu_control = ALU_CTRL_ADD;
        endcase
      end
      default:       alu_control = ALU_CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Multicycle RV32I main controller: state register, next-state logic and per-state
// datapath control decode. Outputs are forced idle while rst is high.
module cpu_multicycle_control
  import cpu_multicycle_control_pkg::*;
#(
  parameter bit RESET_STATE_TRAP = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  cpu_multicycle_control_if.master bus
);

  localparam state_t RESET_STATE = RESET_STATE_TRAP ? S_TRAP : S_FETCH;

  state_t     state_r;
  state_t     state_next_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;
  logic [6:0] opcode_s;
  logic [2:0] alu_control_s;
  logic       unused_s;

  assign opcode_s = bus.instr[6:0];
  assign unused_s = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; memory states hold until mem_ready.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH:     state_next_s = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_s)
          OP_LOAD, OP_STORE: state_next_s = S_MEM_ADR;
          OP_R:              state_next_s = S_EXEC_R;
          OP_I:              state_next_s = S_EXEC_I;
          OP_BRANCH:         state_next_s = S_BRANCH;
          OP_JAL:            state_next_s = S_JAL;
          OP_JALR:           state_next_s = S_JALR;
          OP_LUI:            state_next_s = S_LUI;
          OP_AUIPC:          state_next_s = S_AUIPC;
          default:           state_next_s = S_TRAP;
        endcase
      end
      S_MEM_ADR:   state_next_s = (opcode_s == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next_s = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next_s = S_FETCH;
      S_MEM_WRITE: state_next_s = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_next_s = S_ALU_WB;
      S_EXEC_I:    state_next_s = S_ALU_WB;
      S_ALU_WB:    state_next_s = S_FETCH;
      S_BRANCH:    state_next_s = S_FETCH;
      S_JAL:       state_next_s = S_ALU_WB;
      S_JALR:      state_next_s = S_JAL_LINK;
      S_JAL_LINK:  state_next_s = S_ALU_WB;
      S_LUI:       state_next_s = S_ALU_WB;
      S_AUIPC:     state_next_s = S_ALU_WB;
      S_TRAP:      state_next_s = S_TRAP;
      default:     state_next_s = S_TRAP;
    endcase
  end

  // Per-state control decode; everything idles at zero unless the state asks.
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_req    = 1'b1;
        ctrl_s.alu_src_a  = ALU_SRC_A_PC;
        ctrl_s.alu_src_b  = ALU_SRC_B_FOUR;
        ctrl_s.result_src = RESULT_SRC_ALU;
        ctrl_s.ir_write   = bus.mem_ready;
        ctrl_s.pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl_s.imm_src   = decode_imm_src(opcode_s);
        ctrl_s.alu_src_a = ALU_SRC_A_OLD_PC;
        ctrl_s.alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEM_ADR: begin
        ctrl_s.imm_src   = (opcode_s == OP_STORE) ? IMM_SRC_S : IMM_SRC_I;
        ctrl_s.alu_src_a = ALU_SRC_A_RS1;
        ctrl_s.alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEM_READ: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.adr_src = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_s.result_src = RESULT_SRC_MEM;
        ctrl_s.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.mem_we  = 1'b1;
        ctrl_s.adr_src = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_s.alu_src_a = ALU_SRC_A_RS1;
        ctrl_s.alu_src_b = ALU_SRC_B_RS2;
        ctrl_s.alu_op    = ALU_OP_RTYPE;
      end
      S_EXEC_I: begin
        ctrl_s.alu_src_a = ALU_SRC_A_RS1;
        ctrl_s.alu_src_b = ALU_SRC_B_IMM;
        ctrl_s.alu_op    = ALU_OP_ITYPE;
      end
      S_ALU_WB: begin
        ctrl_s.result_src = RESULT_SRC_ALUOUT;
        ctrl_s.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a  = ALU_SRC_A_RS1;
        ctrl_s.alu_src_b  = ALU_SRC_B_RS2;
        ctrl_s.alu_op     = ALU_OP_SUB;
        ctrl_s.result_src = RESULT_SRC_ALUOUT;
        ctrl_s.pc_write   = bus.branch_taken;
      end
      S_JAL: begin
        ctrl_s.alu_src_a  = ALU_SRC_A_OLD_PC;
        ctrl_s.alu_src_b  = ALU_SRC_B_FOUR;
        ctrl_s.result_src = RESULT_SRC_ALUOUT;
        ctrl_s.pc_write   = 1'b1;
      end
      S_JALR: begin
        ctrl_s.alu_src_a  = ALU_SRC_A_RS1;
        ctrl_s.alu_src_b  = ALU_SRC_B_IMM;
        ctrl_s.result_src = RESULT_SRC_ALU;
        ctrl_s.pc_write   = 1'b1;
      end
      S_JAL_LINK: begin
        ctrl_s.alu_src_a = ALU_SRC_A_OLD_PC;
        ctrl_s.alu_src_b = ALU_SRC_B_FOUR;
      end
      S_LUI: begin
        ctrl_s.imm_src   = IMM_SRC_U;
        ctrl_s.alu_src_b = ALU_SRC_B_IMM;
        ctrl_s.alu_op    = ALU_OP_PASS_B;
      end
      S_AUIPC: begin
        ctrl_s.imm_src   = IMM_SRC_U;
        ctrl_s.alu_src_a = ALU_SRC_A_OLD_PC;
        ctrl_s.alu_src_b = ALU_SRC_B_IMM;
      end
      S_TRAP:  ctrl_s.trap = 1'b1;
      default: ctrl_s.trap = 1'b1;
    endcase
  end

  // Reset masks every strobe so a pending memory response is not acted on.
  always_comb begin
    ctrl_out_s = '0;
    if (rst) begin
      ctrl_out_s = '0;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  cpu_alu_decoder u_alu_decoder (
    .alu_op      (ctrl_out_s.alu_op),
    .funct3      (bus.instr[14:12]),
    .funct7_5    (bus.instr[30]),
    .alu_control (alu_control_s)
  );

  assign bus.mem_req     = ctrl_out_s.mem_req;
  assign bus.mem_we      = ctrl_out_s.mem_we;
  assign bus.adr_src     = ctrl_out_s.adr_src;
  assign bus.ir_write    = ctrl_out_s.ir_write;
  assign bus.pc_write    = ctrl_out_s.pc_write;
  assign bus.reg_write   = ctrl_out_s.reg_write;
  assign bus.imm_src     = ctrl_out_s.imm_src;
  assign bus.alu_src_a   = ctrl_out_s.alu_src_a;
  assign bus.alu_src_b   = ctrl_out_s.alu_src_b;
  assign bus.alu_control = alu_control_s;
  assign bus.result_src  = ctrl_out_s.result_src;
  assign bus.trap        = ctrl_out_s.trap;

endmodule
